// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C EEPROM slave.
// State encoding, default device nibble and bus-level ACK/NACK values.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK
    } state_t;

    localparam logic [3:0] DEV_HI_DEF = 4'b1010;
    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with START, STOP and SCL edge detection.
// Stage 1 and 2 synchronize; stage 3 holds the previous synchronized value.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda_s    = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 256x8 I2C EEPROM slave with page buffer and timed write cycle.
// Define I2C_SLAVE_WP_EN to make wp block memory commits.
module i2c_eeprom_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [3:0] DEV_HI    = DEV_HI_DEF,
    parameter int         PAGE_SIZE = 8,
    parameter int         WR_CYC    = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [2:0] a_pins,
    input  logic       wp,
    output logic       busy,
    output logic       byte_wr
);

    localparam int         PW    = $clog2(PAGE_SIZE);
    localparam int         TW    = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
    localparam logic [7:0] PMASK = 8'(PAGE_SIZE - 1);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t                 state_q;
    logic [2:0]             bitcnt_q;
    logic [7:0]             shreg_q;
    logic [7:0]             ptr_q;
    logic                   sda_oe_q;
    logic                   busy_q;
    logic                   byte_wr_q;
    logic [TW-1:0]          timer_q;
    logic                   rw_q;
    logic                   ph_q;
    logic                   load_q;
    logic [PAGE_SIZE-1:0]   pvalid_q;
    logic [7:0]             pbuf_q [PAGE_SIZE];
    logic [7:0]             mem_q  [256];

    logic [7:0] rx_byte, mem_rd, ptr_pg_d;
    logic       dev_hit, commit_en;

    assign rx_byte  = {shreg_q[6:0], sda_s};
    assign dev_hit  = rx_byte[7:1] == {DEV_HI, a_pins};
    assign mem_rd   = mem_q[ptr_q];
    assign ptr_pg_d = (ptr_q & ~PMASK) | ((ptr_q + 8'd1) & PMASK);

`ifdef I2C_SLAVE_WP_EN
    assign commit_en = ~wp;
`else
    logic unused_wp;
    assign unused_wp = wp;
    assign commit_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            byte_wr_q <= 1'b0;
            timer_q   <= '0;
            rw_q      <= 1'b0;
            ph_q      <= 1'b0;
            load_q    <= 1'b0;
            pvalid_q  <= '0;
        end else begin
            byte_wr_q <= 1'b0;
            // write-cycle timer runs regardless of bus activity
            if (busy_q) begin
                if (timer_q == '0) busy_q <= 1'b0;
                else timer_q <= timer_q - 1'b1;
            end
            if (start) begin
                state_q  <= DEV;
                bitcnt_q <= '0;
                pvalid_q <= '0;
                sda_oe_q <= 1'b0;
                ph_q     <= 1'b0;
                load_q   <= 1'b0;
            end else if (stop) begin
                if (pvalid_q != '0 && commit_en) begin
                    for (int i = 0; i < PAGE_SIZE; i++)
                        if (pvalid_q[i])
                            mem_q[(ptr_q & ~PMASK) | 8'(i)] <= pbuf_q[i];
                    busy_q  <= 1'b1;
                    timer_q <= TW'(WR_CYC - 1);
                end
                state_q  <= IDLE;
                pvalid_q <= '0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    DEV, WADDR, WDATA: if (scl_rise) begin
                        shreg_q  <= rx_byte;
                        bitcnt_q <= bitcnt_q + 3'd1;
                        ph_q     <= 1'b0;
                        if (bitcnt_q == 3'd7) begin
                            if (state_q == DEV) begin
                                rw_q    <= rx_byte[0];
                                state_q <= (dev_hit && !busy_q) ? DEV_ACK : IDLE;
                            end else if (state_q == WADDR) begin
                                ptr_q   <= rx_byte;
                                state_q <= WADDR_ACK;
                            end else begin
                                pbuf_q[ptr_q[PW-1:0]]   <= rx_byte;
                                pvalid_q[ptr_q[PW-1:0]] <= 1'b1;
                                byte_wr_q <= 1'b1;
                                ptr_q     <= ptr_pg_d;
                                state_q   <= WDATA_ACK;
                            end
                        end
                    end
                    // first fall drives ACK, second fall ends the 9th clock
                    DEV_ACK, WADDR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ph_q) begin
                            sda_oe_q <= ~ACK;
                            ph_q     <= 1'b1;
                        end else begin
                            ph_q     <= 1'b0;
                            bitcnt_q <= '0;
                            if (state_q == DEV_ACK && rw_q) begin
                                shreg_q  <= mem_rd;
                                sda_oe_q <= ~mem_rd[7];
                                state_q  <= RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= (state_q == DEV_ACK) ? WADDR : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (load_q) begin
                                load_q   <= 1'b0;
                                shreg_q  <= mem_rd;
                                sda_oe_q <= ~mem_rd[7];
                            end else begin
                                sda_oe_q <= ~shreg_q[6];
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                            end
                        end else if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= RACK;
                                ph_q    <= 1'b0;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_fall && !ph_q) begin
                            sda_oe_q <= 1'b0;
                            ph_q     <= 1'b1;
                        end else if (scl_rise && ph_q) begin
                            ph_q <= 1'b0;
                            if (sda_s == NACK) begin
                                state_q <= IDLE;
                            end else begin
                                ptr_q    <= ptr_q + 8'd1;
                                load_q   <= 1'b1;
                                bitcnt_q <= '0;
                                state_q  <= RDATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign byte_wr = byte_wr_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Self-checking bench for i2c_eeprom_slave: bus-level master tasks,
// read-data scoreboard and a table of memory readback vectors.
module tb_i2c_eeprom_slave;
    import i2c_slave_pkg::*;

    localparam int WRC = 1000;
    localparam int Q   = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       wp = 1'b0;
    logic [2:0] a_pins = 3'b000;
    logic       sda_oe, busy, byte_wr;
    logic       scl_in, sda_in;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .DEV_HI    (4'b1010),
        .PAGE_SIZE (8),
        .WR_CYC    (WRC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .a_pins  (a_pins),
        .wp      (wp),
        .busy    (busy),
        .byte_wr (byte_wr)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic       ack_q[$];

    int bw_cnt = 0, oe_cnt = 0, busy_run = 0, busy_last = 0;

    always @(negedge clk) begin
        if (byte_wr === 1'b1) bw_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
        if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            busy_last = busy_run;
            busy_run  = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic qtr;
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_m = b;
        qtr;
        scl_m = 1'b1;
        qtr;
        @(negedge clk);
        s = sda_in;
        qtr;
        scl_m = 1'b0;
        qtr;
    endtask

    task automatic start_c;
        sda_m = 1'b1; qtr;
        scl_m = 1'b1; qtr;
        sda_m = 1'b0; qtr;
        scl_m = 1'b0; qtr;
    endtask

    task automatic stop_c;
        sda_m = 1'b0; qtr;
        scl_m = 1'b1; qtr;
        sda_m = 1'b1; qtr;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        ack_q.push_back(exp_ack);
        bit_x(1'b1, s);
        check(nm, 32'(s), 32'(ack_q.pop_front()));
    endtask

    task automatic rd_byte(input logic mack, input string nm);
        logic [7:0] d;
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(mack, s);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0h want none queued", nm, d);
        end else begin
            check(nm, 32'(d), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic rand_read(input logic [7:0] a, input int n);
        start_c;
        wr_byte(8'hA0, 1'b0, "rr_devw");
        wr_byte(a, 1'b0, "rr_addr");
        start_c;
        wr_byte(8'hA1, 1'b0, "rr_devr");
        for (int i = 0; i < n; i++) rd_byte(i == n - 1, "rd_data");
    endtask

    task automatic wait_busy;
        for (int i = 0; i < 4 * WRC && busy; i++) @(negedge clk);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } vec_t;

    vec_t vt[5];
    logic [7:0] wd[4];
    int bw0, oe0;

    initial begin
        vt[0] = '{8'h06, 8'h11};
        vt[1] = '{8'h07, 8'h22};
        vt[2] = '{8'h00, 8'h33};
        vt[3] = '{8'h10, 8'hA1};
        vt[4] = '{8'h13, 8'hD4};
        wd = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_wr", 32'(byte_wr), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        bw0 = bw_cnt;
        start_c;
        wr_byte(8'hA0, 1'b0, "w_dev");
        wr_byte(8'h10, 1'b0, "w_addr");
        for (int i = 0; i < 4; i++) wr_byte(wd[i], 1'b0, "w_data");
        stop_c;
        repeat (4) @(posedge clk);
        #1;
        check("byte_wr_cnt", 32'(bw_cnt - bw0), 32'd4);
        check("busy_after_stop", 32'(busy), 32'd1);

        oe0 = oe_cnt;
        start_c;
        wr_byte(8'hA0, 1'b1, "busy_nack");
        stop_c;
        check("busy_no_oe", 32'(oe_cnt - oe0), 32'd0);
        check("busy_still", 32'(busy), 32'd1);
        wait_busy;
        check("busy_len", 32'(busy_last), 32'(WRC));

        for (int i = 0; i < 4; i++) exp_q.push_back(wd[i]);
        rand_read(8'h10, 4);
        check("rd_end_idle", 32'(dut.state_q), 32'(IDLE));
        stop_c;

        start_c;
        wr_byte(8'hA0, 1'b0, "pg_dev");
        wr_byte(8'h06, 1'b0, "pg_addr");
        wr_byte(8'h11, 1'b0, "pg_d0");
        wr_byte(8'h22, 1'b0, "pg_d1");
        wr_byte(8'h33, 1'b0, "pg_d2");
        stop_c;
        wait_busy;

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vt[i].d);
            rand_read(vt[i].a, 1);
            stop_c;
        end

        oe0 = oe_cnt;
        start_c;
        wr_byte(8'hA4, 1'b1, "wrong_dev");
        stop_c;
        check("wrong_no_oe", 32'(oe_cnt - oe0), 32'd0);

        start_c;
        wr_byte(8'hA0, 1'b0, "ff_dev");
        wr_byte(8'hFF, 1'b0, "ff_addr");
        wr_byte(8'h5A, 1'b0, "ff_data");
        stop_c;
        wait_busy;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h33);
        rand_read(8'hFF, 2);
        stop_c;

        start_c;
        wr_byte(8'hA0, 1'b0, "sr_dev");
        wr_byte(8'h12, 1'b0, "sr_addr");
        wr_byte(8'h44, 1'b0, "sr_data");
        start_c;
        wr_byte(8'hA1, 1'b0, "sr_devr");
        exp_q.push_back(8'hD4);
        rd_byte(1'b1, "sr_rd");
        stop_c;
        repeat (4) @(posedge clk);
        #1;
        check("sr_no_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'hC3);
        rand_read(8'h12, 1);
        stop_c;

        begin
            logic s;
            start_c;
            wr_byte(8'hA0, 1'b0, "rst_dev");
            wr_byte(8'h10, 1'b0, "rst_addr");
            start_c;
            wr_byte(8'hA1, 1'b0, "rst_devr");
            bit_x(1'b1, s);
            sda_m = 1'b1; qtr;
            scl_m = 1'b1; qtr;
            check("rd_drive", 32'(sda_oe), 32'd1);
            @(posedge clk); #1 reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("mid_rst_oe", 32'(sda_oe), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            scl_m = 1'b0; qtr;
            stop_c;
        end
        exp_q.push_back(8'hA1);
        rand_read(8'h10, 1);
        stop_c;

        wp = 1'b1;
        start_c;
        wr_byte(8'hA0, 1'b0, "wp_dev");
        wr_byte(8'h11, 1'b0, "wp_addr");
        wr_byte(8'h77, 1'b0, "wp_data");
        stop_c;
        repeat (4) @(posedge clk);
        #1;
`ifdef I2C_SLAVE_WP_EN
        check("wp_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'hB2);
`else
        check("wp_busy", 32'(busy), 32'd1);
        wait_busy;
        exp_q.push_back(8'h77);
`endif
        wp = 1'b0;
        rand_read(8'h11, 1);
        stop_c;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
